mmio_router: RTL and testbench

Parametrised data-side address router between the CPU data port, the cache manage unit and up to NUM_DEV memory-mapped devices (vmem, timer, keyboard, loader, …).
- Decodes the top address nibble. Non-device accesses pass through to the cache.
- Device accesses run a per-device handshake: a minimum latency, then the device's ready signal.
- Generates the CPU stall and the byte-lane data routing for the device bus.

---
 rtl/mmio_router_if.sv | 46 ++++
 rtl/mmio_router.sv | 191 +++++++++++++++++++
 tb/tb_mmio_router.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_router_if.sv
// Bus bundle between the CPU data port, cache manage unit and MMIO devices.
// The router takes the slave modport; the environment (CPU/cache/devices) takes master.
interface mmio_router_if #(
    parameter int NUM_DEV = 4,
    parameter int ADDR_W  = 30
);
    logic                    cpu_read;
    logic                    cpu_write;
    logic [ADDR_W-1:0]       cpu_addr;
    logic [31:0]             cpu_wdata;
    logic [3:0]              cpu_byte_en;
    logic [31:0]             cpu_rdata;
    logic                    cpu_stall;
    logic                    mem_read;
    logic                    mem_write;
    logic [31:0]             mem_rdata;
    logic                    mem_stall;
    logic [NUM_DEV-1:0]      dev_en;
    logic                    dev_we;
    logic [ADDR_W+1:0]       dev_addr;
    logic [7:0]              dev_wdata;
    logic [31:0]             dev_wword;
    logic [32*NUM_DEV-1:0]   dev_rdata;
    logic [NUM_DEV-1:0]      dev_rdy;
    logic                    err;

    modport slave (
        input  cpu_read, cpu_write, cpu_addr, cpu_wdata, cpu_byte_en,
        output cpu_rdata, cpu_stall,
        output mem_read, mem_write,
        input  mem_rdata, mem_stall,
        output dev_en, dev_we, dev_addr, dev_wdata, dev_wword,
        input  dev_rdata, dev_rdy,
        output err
    );

    modport master (
        output cpu_read, cpu_write, cpu_addr, cpu_wdata, cpu_byte_en,
        input  cpu_rdata, cpu_stall,
        input  mem_read, mem_write,
        output mem_rdata, mem_stall,
        input  dev_en, dev_we, dev_addr, dev_wdata, dev_wword,
        output dev_rdata, dev_rdy,
        input  err
    );
endinterface

// File: rtl/mmio_router.sv
// Data-side address router: cache pass-through or per-device MMIO handshake.
// Optional MMIO_TIMEOUT_EN forces completion (0xDEADBEEF, sticky err) after TIMEOUT WAIT cycles.
//
// state | meaning
// IDLE  | decode; pass non-device traffic to the cache, launch device access on a hit
// WAIT  | device selected; minimum latency counts down, then wait for dev_rdy
// DONE  | one unstalled cycle presenting the captured device read data
module mmio_router #(
    parameter int                    NUM_DEV  = 4,
    parameter int                    ADDR_W   = 30,
    parameter int                    DATA_W   = 32,
    parameter int                    SEL_HI   = 29,
    parameter int                    SEL_LO   = 26,
    parameter logic [4*NUM_DEV-1:0]  DEV_CODE = 16'hFEDC,
    parameter logic [4*NUM_DEV-1:0]  DEV_LAT  = 16'h1001,
    parameter int                    TIMEOUT  = 64
) (
    input  logic          clk,
    input  logic          rst,
    mmio_router_if.slave  bus
);

    localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;

    logic                w_req;
    logic [3:0]          w_sel;
    logic                w_hit_any;
    logic [IDX_W-1:0]    w_hit_idx;
    logic [1:0]          w_off;
    logic [7:0]          w_lane;
    logic [NUM_DEV-1:0]  w_dev_en;
    logic                w_dev_we;

`ifdef MMIO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]       r_tcnt, w_tcnt_nxt;
    logic                r_err, w_err_nxt;
`else
    logic [31:0]         w_unused_timeout;
    assign w_unused_timeout = 32'(TIMEOUT);
`endif

    assign w_req = bus.cpu_read | bus.cpu_write;
    assign w_sel = bus.cpu_addr[SEL_HI:SEL_LO];

    // Scan high to low so the lowest matching index wins on overlapping codes.
    always_comb begin
        w_hit_any = 1'b0;
        w_hit_idx = '0;
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if (w_req && (w_sel == DEV_CODE[4*i +: 4])) begin
                w_hit_any = 1'b1;
                w_hit_idx = IDX_W'(i);
            end
        end
    end

    // Byte offset from one-hot enables; anything else falls back to lane 0.
    always_comb begin
        case (bus.cpu_byte_en)
            4'b1000: w_off = 2'd0;
            4'b0100: w_off = 2'd1;
            4'b0010: w_off = 2'd2;
            4'b0001: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
    end

    always_comb begin
        case (w_off)
            2'd0:    w_lane = bus.cpu_wdata[7:0];
            2'd1:    w_lane = bus.cpu_wdata[15:8];
            2'd2:    w_lane = bus.cpu_wdata[23:16];
            default: w_lane = bus.cpu_wdata[31:24];
        endcase
    end

    assign bus.dev_addr  = {bus.cpu_addr, w_off};
    assign bus.dev_wdata = w_lane;
    assign bus.dev_wword = bus.cpu_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rdata <= w_rdata_nxt;
        end
    end

`ifdef MMIO_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            r_tcnt <= w_tcnt_nxt;
            r_err  <= w_err_nxt;
        end
    end
    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_cnt_nxt     = r_cnt;
        w_rdata_nxt   = r_rdata;
        w_dev_en      = '0;
        w_dev_we      = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.cpu_stall = 1'b0;
        bus.cpu_rdata = r_rdata;
`ifdef MMIO_TIMEOUT_EN
        w_tcnt_nxt    = r_tcnt;
        w_err_nxt     = r_err;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_hit_any) begin
                    w_dev_en      = NUM_DEV'(1) << w_hit_idx;
                    w_dev_we      = bus.cpu_write;
                    bus.cpu_stall = 1'b1;
                    w_idx_nxt     = w_hit_idx;
                    w_cnt_nxt     = DEV_LAT[4*w_hit_idx +: 4];
`ifdef MMIO_TIMEOUT_EN
                    w_tcnt_nxt    = TW'(TIMEOUT - 1);
`endif
                    w_state_nxt   = ST_WAIT;
                end else begin
                    bus.mem_read  = bus.cpu_read;
                    bus.mem_write = bus.cpu_write;
                    bus.cpu_rdata = bus.mem_rdata;
                    bus.cpu_stall = bus.mem_stall;
                end
            end
            ST_WAIT: begin
                w_dev_en      = NUM_DEV'(1) << r_idx;
                w_dev_we      = bus.cpu_write;
                bus.cpu_stall = 1'b1;
                if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
                if ((r_cnt == 4'd0) && bus.dev_rdy[r_idx]) begin
                    w_rdata_nxt = bus.dev_rdata[32*r_idx +: 32];
                    w_state_nxt = ST_DONE;
                end
`ifdef MMIO_TIMEOUT_EN
                // Terminal count of the total-WAIT down-counter forces completion.
                else if (r_tcnt == '0) begin
                    w_rdata_nxt = 32'hDEAD_BEEF;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_tcnt_nxt = r_tcnt - TW'(1);
                end
`endif
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Device strobes are held off for the whole reset cycle, even with a request pending.
    assign bus.dev_en = rst ? '0   : w_dev_en;
    assign bus.dev_we = rst ? 1'b0 : w_dev_we;

endmodule

// File: tb/tb_mmio_router.sv
// Directed bench for mmio_router: table of IDLE-cycle decode vectors plus handshake sequences.
// Build with MMIO_TIMEOUT_EN defined to also exercise the forced-timeout path (TIMEOUT=8).
module tb_mmio_router;

    localparam int NUM_DEV = 4;
    localparam int ADDR_W  = 30;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mmio_router_if #(.NUM_DEV(NUM_DEV), .ADDR_W(ADDR_W)) bus ();

`ifdef MMIO_TIMEOUT_EN
    mmio_router #(.NUM_DEV(NUM_DEV), .ADDR_W(ADDR_W), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`else
    mmio_router #(.NUM_DEV(NUM_DEV), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        mstall;
        logic [31:0] mrdata;
        logic        e_mrd;
        logic        e_mwr;
        logic        e_stall;
        logic [3:0]  e_en;
        logic        e_we;
        logic [31:0] e_daddr;
        logic [7:0]  e_dwdata;
        logic        chk_rdata;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one device access from the current (IDLE) cycle through DONE; ends in the DONE cycle.
    task automatic run_access(input string name, input int rdy_delay, input logic [3:0] rdy_mask,
                              input int e_stall, input logic [3:0] e_en, input int e_we,
                              input logic chk_rd, input logic [31:0] e_rdata);
        int          n_stall;
        int          n_we;
        logic [3:0]  en_seen;
        logic        mem_seen;
        logic [31:0] rdata;
        logic [3:0]  done_en;
        n_stall  = 0;
        n_we     = 0;
        en_seen  = '0;
        mem_seen = 1'b0;
        rdata    = '0;
        done_en  = 4'hF;
        for (int k = 0; k < 64; k++) begin
            bus.dev_rdy = (k >= rdy_delay) ? rdy_mask : 4'b0000;
            #1;
            mem_seen = mem_seen | bus.mem_read | bus.mem_write;
            if (!bus.cpu_stall) begin
                rdata   = bus.cpu_rdata;
                done_en = bus.dev_en;
                break;
            end
            n_stall++;
            en_seen = en_seen | bus.dev_en;
            if (bus.dev_we) n_we++;
            @(negedge clk);
        end
        chk({name, "_stall_cycles"}, 32'(n_stall), 32'(e_stall));
        chk({name, "_dev_en"}, {28'd0, en_seen}, {28'd0, e_en});
        chk({name, "_we_cycles"}, 32'(n_we), 32'(e_we));
        chk({name, "_no_cache_req"}, {31'd0, mem_seen}, 32'd0);
        chk({name, "_done_dev_en"}, {28'd0, done_en}, 32'd0);
        if (chk_rd) chk({name, "_rdata"}, rdata, e_rdata);
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic [29:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        bus.cpu_read    = rd;
        bus.cpu_write   = wr;
        bus.cpu_addr    = addr;
        bus.cpu_wdata   = wdata;
        bus.cpu_byte_en = be;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{1'b1, 1'b0, 30'h0000_0100, 32'h0000_0000, 4'b1000, 1'b1, 32'hCAFE_0001,
                    1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 32'h0000_0400, 8'h00, 1'b1, 32'hCAFE_0001};
        vecs[1] = '{1'b1, 1'b0, 30'h0000_0100, 32'h0000_0000, 4'b1000, 1'b0, 32'h0BAD_0002,
                    1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 32'h0000_0400, 8'h00, 1'b1, 32'h0BAD_0002};
        vecs[2] = '{1'b0, 1'b1, 30'h0000_0200, 32'h1122_3344, 4'b0001, 1'b0, 32'h0000_0000,
                    1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0000_0803, 8'h11, 1'b1, 32'h0000_0000};
        vecs[3] = '{1'b0, 1'b0, 30'h3000_0000, 32'h1122_3344, 4'b1000, 1'b1, 32'h0000_0005,
                    1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 32'hC000_0000, 8'h44, 1'b1, 32'h0000_0005};
        vecs[4] = '{1'b0, 1'b1, 30'h3000_0002, 32'h4142_4344, 4'b0100, 1'b0, 32'h0000_0000,
                    1'b0, 1'b0, 1'b1, 4'b0001, 1'b1, 32'hC000_0009, 8'h43, 1'b0, 32'h0000_0000};
        vecs[5] = '{1'b1, 1'b0, 30'h3C00_0010, 32'hA1B2_C3D4, 4'b0010, 1'b0, 32'h0000_0000,
                    1'b0, 1'b0, 1'b1, 4'b1000, 1'b0, 32'hF000_0042, 8'hB2, 1'b0, 32'h0000_0000};
        vecs[6] = '{1'b0, 1'b1, 30'h0000_0004, 32'hA1B2_C3D4, 4'b1100, 1'b0, 32'h0000_0000,
                    1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0000_0010, 8'hD4, 1'b1, 32'h0000_0000};
        vecs[7] = '{1'b1, 1'b0, 30'h3800_0001, 32'hA1B2_C3D4, 4'b0000, 1'b1, 32'h0000_0000,
                    1'b0, 1'b0, 1'b1, 4'b0100, 1'b0, 32'hE000_0004, 8'hD4, 1'b0, 32'h0000_0000};
        vecs[8] = '{1'b1, 1'b0, 30'h2C00_0000, 32'hA1B2_C3D4, 4'b1000, 1'b1, 32'h0000_0077,
                    1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 32'hB000_0000, 8'hD4, 1'b1, 32'h0000_0077};
        vecs[9] = '{1'b1, 1'b0, 30'h3400_0008, 32'hA1B2_C3D4, 4'b0001, 1'b0, 32'h0000_0000,
                    1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 32'hD000_0023, 8'hA1, 1'b0, 32'h0000_0000};

        rst           = 1'b1;
        set_req(1'b0, 1'b0, '0, '0, 4'b1000);
        bus.mem_rdata = '0;
        bus.mem_stall = 1'b1;
        bus.dev_rdy   = '0;
        bus.dev_rdata = {32'h3333_0003, 32'h2222_0002, 32'h1234_5678, 32'hAAAA_0000};

        // Reset state, including a device request present during reset.
        @(negedge clk);
        #1;
        chk("rst_dev_en", {28'd0, bus.dev_en}, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_stall_mirror", {31'd0, bus.cpu_stall}, 32'd1);
        @(negedge clk);
        set_req(1'b0, 1'b1, 30'h3000_0000, 32'h0, 4'b1000);
        #1;
        chk("rst_req_dev_en", {28'd0, bus.dev_en}, 32'd0);
        chk("rst_req_dev_we", {31'd0, bus.dev_we}, 32'd0);
        set_req(1'b0, 1'b0, '0, '0, 4'b1000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // IDLE-cycle decode vectors; the request is dropped before the edge so state stays IDLE.
        for (int v = 0; v < 10; v++) begin
            set_req(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].be);
            bus.mem_stall = vecs[v].mstall;
            bus.mem_rdata = vecs[v].mrdata;
            #1;
            chk($sformatf("v%0d_mem_read", v), {31'd0, bus.mem_read}, {31'd0, vecs[v].e_mrd});
            chk($sformatf("v%0d_mem_write", v), {31'd0, bus.mem_write}, {31'd0, vecs[v].e_mwr});
            chk($sformatf("v%0d_cpu_stall", v), {31'd0, bus.cpu_stall}, {31'd0, vecs[v].e_stall});
            chk($sformatf("v%0d_dev_en", v), {28'd0, bus.dev_en}, {28'd0, vecs[v].e_en});
            chk($sformatf("v%0d_dev_we", v), {31'd0, bus.dev_we}, {31'd0, vecs[v].e_we});
            chk($sformatf("v%0d_dev_addr", v), bus.dev_addr, vecs[v].e_daddr);
            chk($sformatf("v%0d_dev_wdata", v), {24'd0, bus.dev_wdata}, {24'd0, vecs[v].e_dwdata});
            chk($sformatf("v%0d_dev_wword", v), bus.dev_wword, vecs[v].wdata);
            if (vecs[v].chk_rdata)
                chk($sformatf("v%0d_cpu_rdata", v), bus.cpu_rdata, vecs[v].e_rdata);
            set_req(1'b0, 1'b0, '0, '0, 4'b1000);
            @(negedge clk);
        end

        // Cache read held across a 3-cycle cache stall.
        set_req(1'b1, 1'b0, 30'h0000_0100, 32'h0, 4'b1000);
        bus.mem_rdata = 32'h5A5A_1234;
        for (int c = 0; c < 4; c++) begin
            bus.mem_stall = (c < 3);
            #1;
            chk($sformatf("pass%0d_stall", c), {31'd0, bus.cpu_stall}, {31'd0, c < 3});
            chk($sformatf("pass%0d_mem_read", c), {31'd0, bus.mem_read}, 32'd1);
            chk($sformatf("pass%0d_dev_en", c), {28'd0, bus.dev_en}, 32'd0);
            chk($sformatf("pass%0d_rdata", c), bus.cpu_rdata, 32'h5A5A_1234);
            @(negedge clk);
        end
        set_req(1'b0, 1'b0, '0, '0, 4'b1000);
        bus.mem_stall = 1'b0;
        @(negedge clk);

        // Write to dev0 (LAT=1, ready at once): 3 stall cycles then DONE.
        set_req(1'b0, 1'b1, 30'h3000_0002, 32'h4142_4344, 4'b0100);
        run_access("wr_dev0", 0, 4'b1111, 3, 4'b0001, 3, 1'b0, 32'h0);
        @(negedge clk);
        set_req(1'b0, 1'b0, '0, '0, 4'b1000);
        @(negedge clk);

        // Read dev1 (LAT=0) with ready arriving 4 cycles after the request.
        set_req(1'b1, 1'b0, 30'h3400_0000, 32'h0, 4'b1000);
        run_access("rd_dev1", 4, 4'b0010, 5, 4'b0010, 0, 1'b1, 32'h1234_5678);
        @(negedge clk);
        set_req(1'b0, 1'b0, '0, '0, 4'b1000);
        @(negedge clk);

        // Back-to-back dev2 then dev3 reads, one DONE cycle between.
        set_req(1'b1, 1'b0, 30'h3800_0000, 32'h0, 4'b1000);
        run_access("b2b_dev2", 0, 4'b1111, 2, 4'b0100, 0, 1'b1, 32'h2222_0002);
        @(negedge clk);
        set_req(1'b1, 1'b0, 30'h3C00_0000, 32'h0, 4'b1000);
        run_access("b2b_dev3", 0, 4'b1111, 3, 4'b1000, 0, 1'b1, 32'h3333_0003);
        @(negedge clk);
        set_req(1'b0, 1'b0, '0, '0, 4'b1000);
        @(negedge clk);

        // Reset during the 2nd WAIT cycle aborts; the held request restarts from IDLE.
        bus.dev_rdy = '0;
        set_req(1'b1, 1'b0, 30'h3400_0000, 32'h0, 4'b1000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_dev_en", {28'd0, bus.dev_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_access("restart_dev1", 0, 4'b1111, 2, 4'b0010, 0, 1'b1, 32'h1234_5678);
        @(negedge clk);
        set_req(1'b0, 1'b0, '0, '0, 4'b1000);
        @(negedge clk);

`ifdef MMIO_TIMEOUT_EN
        // dev_rdy never rises: forced completion after 8 WAIT cycles.
        set_req(1'b1, 1'b0, 30'h3400_0000, 32'h0, 4'b1000);
        run_access("timeout", 1000, 4'b0000, 9, 4'b0010, 0, 1'b1, 32'hDEAD_BEEF);
        chk("timeout_err_done", {31'd0, bus.err}, 32'd1);
        @(negedge clk);
        set_req(1'b1, 1'b0, 30'h3800_0000, 32'h0, 4'b1000);
        run_access("after_timeout", 0, 4'b1111, 2, 4'b0100, 0, 1'b1, 32'h2222_0002);
        chk("err_sticky", {31'd0, bus.err}, 32'd1);
        @(negedge clk);
        set_req(1'b0, 1'b0, '0, '0, 4'b1000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("err_cleared", {31'd0, bus.err}, 32'd0);
`else
        chk("err_tied_low", {31'd0, bus.err}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
